serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Parametrised multi-cycle adder: sums two WIDTH-bit operands plus carry-in, DIGIT bits per clock, with a registered ripple carry between slices.
- Start/busy/done handshake toward the controlling datapath.
- Successor to the single-bit combinational full adder: same A/B/Cin/Sum/Cout semantics, generalised in width and slice size, and extended with sequencing, signed overflow and an optional subtract mode.
- Used wherever a wide add may trade latency for area.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT slice cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when idle (busy=0).
- A  input  WIDTH  operand A, captured on the accepted start.
- B  input  WIDTH  operand B, captured on the accepted start.
- Cin  input  1  carry-in, captured on the accepted start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; Sum, Cout and Ovf are valid from this cycle.
- Sum  output  WIDTH  registered result, A+B+Cin modulo 2^WIDTH.
- Cout  output  1  carry out of the MSB.
- Ovf  output  1  two's-complement overflow = carry into MSB XOR Cout.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - busy=0, done=0, Sum=0, Cout=0, Ovf=0.
  - Internal operand, carry and slice-counter registers cleared.
  - An operation in flight is discarded and done never fires for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches A, B and Cin into the carry register, clears the slice index and moves to RUN.
  - busy=1 from that edge.
- RUN:
  - Each edge adds slice k (bits k*DIGIT .. k*DIGIT+DIGIT-1) of the latched operands plus the carry register.
  - The DIGIT-bit partial sum goes to an internal accumulator; the slice carry-out goes to the carry register; k increments.
  - After slice N-1 the state moves to DONE. On that same edge Sum, Cout and Ovf load from the accumulator and final carries; busy=0; done=1.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE with done=0.
  - start=1 during the DONE cycle is accepted exactly as in IDLE (back-to-back operation, no bubble).
- Latency: start accepted at edge 0 -> done high in the cycle after edge N. Throughput is one result per N+1 cycles.
- start while busy=1 is ignored; the operation in flight is unaffected.
- A, B and Cin may change freely after acceptance.
- Sum, Cout and Ovf hold their previous values during RUN. They change only on the completion edge or on reset.
- No intermediate result is visible on the outputs.
- DIGIT=WIDTH gives N=1: one RUN cycle, then DONE.
- Arithmetic is unsigned modulo 2^WIDTH for Sum. Ovf uses the carry into bit WIDTH-1, which is tracked internally on the final slice.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), captured with the operands on the accepted start.
  - Sub=1 computes A + ~B + Cin, i.e. A-B when Cin=1; Cout=1 means no borrow. Ovf is signed-subtract overflow by the same MSB-carry rule.
  - Sub=0 behaves exactly as the base block.
- Undefined:
  - The Sub port is absent and the block is add-only.
  - There is no inversion logic on B.

Test Plan:
- Assert rst_n=0 for 2 cycles -> busy=0, done=0, Sum=0, Cout=0, Ovf=0. Release; no done for 10 idle cycles.
- WIDTH=16, DIGIT=4: A=0x1234, B=0x4321, Cin=0, start at edge 0 -> busy high for 4 cycles; done in the cycle after edge 4; Sum=0x5555, Cout=0, Ovf=0.
- A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0000, Cin=1 -> Sum=0x8000, Cout=0, Ovf=1.
- Hold start=1 continuously with new operands each cycle -> only the operands present at acceptance edges are summed; back-to-back results every 5 cycles; Sum stable during busy.
- Pull rst_n low at the second RUN cycle -> all outputs 0 immediately; no done. A fresh start afterwards completes correctly.
- WIDTH=2, DIGIT=1: exhaustive sweep of all 32 (A,B,Cin) combinations -> {Cout,Sum} equals A+B+Cin for every vector. With SERIAL_ADD_SUB_EN, Sub=1, Cin=1: 0x0005-0x0007 at WIDTH=16 gives Sum=0xFFFE, Cout=0.

Source files
------------

// File: rtl/serial_add.sv
// rtl/serial_add.sv - multi-cycle DIGIT-per-clock adder with start/busy/done handshake
// Optional subtract mode (Sub port, B inverted on capture) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic             carry_q;
  logic [KW-1:0]    k_q;
  logic             accept, last_slice;
  int               k_base;
  logic [DIGIT-1:0] slice_a, slice_b;
  logic [DIGIT:0]   slice_sum;
  logic             msb_carry_in;
  logic [WIDTH-1:0] b_eff;

  // start is honoured in IDLE and in the single DONE cycle, never mid-operation
  assign accept     = start && (state_q != RUN);
  assign last_slice = (k_q == K_LAST);

`ifdef SERIAL_ADD_SUB_EN
  assign b_eff = Sub ? ~B : B;
`else
  assign b_eff = B;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    k_base    = int'(k_q) * DIGIT;
    slice_a   = a_q[k_base +: DIGIT];
    slice_b   = b_q[k_base +: DIGIT];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry_q};
    acc_next  = acc_q;
    acc_next[k_base +: DIGIT] = slice_sum[DIGIT-1:0];
    // carry into the MSB recovered from its sum bit: s = a ^ b ^ c
    msb_carry_in = acc_next[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= b_eff;
      acc_q   <= '0;
      carry_q <= Cin;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_next;
      carry_q <= slice_sum[DIGIT];
      k_q     <= k_q + KW'(1);
      if (last_slice) begin
        Sum  <= acc_next;
        Cout <= slice_sum[DIGIT];
        Ovf  <= msb_carry_in ^ slice_sum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// tb/tb_serial_add.sv - directed self-checking bench for serial_add (16/4 and 2/1 instances)
module tb_serial_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, Cin, sub;
  logic [15:0] A, B;
  logic        busy, done, Cout, Ovf;
  logic [15:0] Sum;

  logic        start2, cin2;
  logic [1:0]  a2, b2;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADD_SUB_EN
    .Sub(sub),
`endif
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  serial_add #(.WIDTH(2), .DIGIT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Cin(cin2),
`ifdef SERIAL_ADD_SUB_EN
    .Sub(1'b0),
`endif
    .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2), .Ovf(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int n;
    logic [15:0] prev;
    logic stable;
    A = a; B = b; Cin = c; sub = s; start = 1'b1;
    step();
    start = 1'b0; A = ~a; B = ~b; Cin = ~c;
    chk({tag, "_busy"}, busy, 1);
    prev = Sum; stable = 1'b1; n = 0;
    while (!done && n < 20) begin
      if (Sum !== prev) stable = 1'b0;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_stable"}, stable, 1);
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_cout"}, Cout, ec);
    chk({tag, "_ovf"}, Ovf, eo);
    step();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cnt, n;
    logic [15:0] prev, va, vb;
    logic [2:0] e3;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_ovf", Ovf, 0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || done2) cnt++;
    end
    chk("idle_no_done", cnt, 0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");

    // start held high: acceptances at cycles 0, 5, 10
    prev = Sum;
    for (int j = 0; j < 15; j++) begin
      A = 16'h1111 * j[15:0]; B = 16'h0F0F + j[15:0]; Cin = 1'b0; start = 1'b1;
      step();
      if (j % 5 == 4) begin
        va = 16'h1111 * (j[15:0] - 16'd4);
        vb = 16'h0F0F + (j[15:0] - 16'd4);
        chk($sformatf("b2b_done_%0d", j), done, 1);
        chk($sformatf("b2b_sum_%0d", j), Sum, va + vb);
      end else begin
        chk($sformatf("b2b_busy_%0d", j), {done, busy}, 2'b01);
        chk($sformatf("b2b_hold_%0d", j), Sum, prev);
      end
      prev = Sum;
    end
    start = 1'b0;
    step();

    A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, Sum, Cout, Ovf}, 0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "after_rst");

    for (int i = 0; i < 32; i++) begin
      a2 = i[4:3]; b2 = i[2:1]; cin2 = i[0]; start2 = 1'b1;
      step();
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 10) begin
        step();
        n++;
      end
      e3 = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
      chk($sformatf("w2_lat_%0d", i), n, 2);
      chk($sformatf("w2_sum_%0d", i), {cout2, sum2}, e3);
      e3 = {a2[1], a2} + {b2[1], b2} + {2'b00, cin2};
      chk($sformatf("w2_ovf_%0d", i), ovf2, e3[2] ^ e3[1]);
      step();
    end

`ifdef SERIAL_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
